dm_arbiter: RTL and testbench

- Shares the single data memory `dm` between two requesters.
- Port 0 is the CPU load/store port (`SCPU` Addr_out/Data_out/mem_w/DMType_out); port 1 is a debug/DMA loader port.
- Sits between requesters and `dm` in `sccomp`: serialises accesses, returns registered read data with a one-cycle ack, and prevents port-1 starvation.
- Provides a stall indication for the CPU while its access is pending.

---
 rtl/dm_arb_pkg.sv | 19 +
 rtl/dm_arb_pick.sv | 23 ++
 rtl/dm_arbiter.sv | 115 +++++++++++
 tb/tb_dm_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// DMType access codes (same encoding as SCPU/dm) and requester port indices.
package dm_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    localparam logic P_CPU = 1'b0;
    localparam logic P_DBG = 1'b1;

endpackage

// File: rtl/dm_arb_pick.sv
// Winner selection between the CPU port and the debug/DMA port. The CPU has
// priority unless it has already won STARVE_LIMIT times in a row against port 1.
module dm_arb_pick
    import dm_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       m0_req,
    input  logic       m1_req,
    input  logic [3:0] starve_cnt,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = m0_req | m1_req;
        grant_idx   = P_CPU;
        if (m1_req && (!m0_req || starve_cnt == 4'(STARVE_LIMIT))) begin
            grant_idx = P_DBG;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-ported data memory. An access is
// granted in IDLE, drives dm combinationally, and is acknowledged in RESP.
//
// Handshake: a requester raises mX_req with stable fields and holds it until it
// sees mX_ack (a one-cycle pulse, rdata valid with it); in the cycle after ack it
// may drop req or present a new request. A req still high in IDLE is a new access.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W       = 7,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [2:0]        m0_dmtype,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ack,
    output logic [31:0]       m0_rdata,
    output logic              m0_stall,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [2:0]        m1_dmtype,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic [31:0]       m1_rdata,
    output logic              dm_we,
    output logic [2:0]        dm_type,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    input  logic [31:0]       dm_dout
);

    arb_state_t  state, next_state;
    logic        owner;
    logic [3:0]  starve_cnt;
    logic        grant_valid, grant_idx;
    logic        start;
    logic        sel_we;
    logic [2:0]  sel_type;
    logic [31:0] sel_addr, sel_wdata;
    logic        unused_addr_bits;

    dm_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .m0_req      (m0_req),
        .m1_req      (m1_req),
        .starve_cnt  (starve_cnt),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign sel_we    = (grant_idx == P_DBG) ? m1_we     : m0_we;
    assign sel_type  = (grant_idx == P_DBG) ? m1_dmtype : m0_dmtype;
    assign sel_addr  = (grant_idx == P_DBG) ? m1_addr   : m0_addr;
    assign sel_wdata = (grant_idx == P_DBG) ? m1_wdata  : m0_wdata;

    // Byte offset and bits above the dm range are ignored; high addresses alias.
    assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};

    assign start = (state == IDLE) && grant_valid;

    always_comb begin
        next_state = state;
        dm_we      = 1'b0;
        dm_type    = '0;
        dm_addr    = '0;
        dm_din     = '0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    dm_we      = sel_we & ~reset;
                    dm_type    = sel_type;
                    dm_addr    = sel_addr[ADDR_W+1:2];
                    dm_din     = sel_wdata;
                    next_state = RESP;
                end
            end
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Gating with reset drops an ack whose RESP cycle is cut short by reset.
    assign m0_ack   = (state == RESP) && (owner == P_CPU) && !reset;
    assign m1_ack   = (state == RESP) && (owner == P_DBG) && !reset;
    assign m0_stall = m0_req & ~m0_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= P_CPU;
            starve_cnt <= '0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            state <= next_state;
            if (start) begin
                owner <= grant_idx;
                if (!sel_we) begin
                    if (grant_idx == P_DBG) m1_rdata <= dm_dout;
                    else                    m0_rdata <= dm_dout;
                end
                if (grant_idx == P_CPU && m1_req) begin
                    if (starve_cnt != 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 4'd1;
                end else begin
                    starve_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a memory model stands in for dm, a reference model
// predicts every grant and pushes the expected ack into a queue for the monitor.
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [2:0]  m0_dmtype, m1_dmtype;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack, m0_stall;
    logic [31:0] m0_rdata, m1_rdata;
    logic        dm_we;
    logic [2:0]  dm_type;
    logic [6:0]  dm_addr;
    logic [31:0] dm_din, dm_dout;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] dm_mem  [128];
    logic [31:0] ref_mem [128];
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(7), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_dmtype(m0_dmtype), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_stall(m0_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_dmtype(m1_dmtype), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .dm_we(dm_we), .dm_type(dm_type), .dm_addr(dm_addr), .dm_din(dm_din),
        .dm_dout(dm_dout)
    );

    // Stand-in for dm: combinational read, write at the clock edge.
    assign dm_dout = dm_mem[dm_addr];
    always @(posedge clk) if (dm_we) dm_mem[dm_addr] <= dm_din;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_busy;
    bit          m_owner;
    int          m_run;
    logic [31:0] m_last [2];

    always @(negedge clk) begin
        if (reset) begin
            check("dm_we_in_reset", 32'(dm_we), 0);
            check("m0_ack_in_reset", 32'(m0_ack), 0);
            check("m1_ack_in_reset", 32'(m1_ack), 0);
            m_busy = 0; m_owner = 0; m_run = 0;
            m_last[0] = '0; m_last[1] = '0;
            exp_q.delete();
        end else begin
            check("m0_ack", 32'(m0_ack), 32'(m_busy && !m_owner));
            check("m1_ack", 32'(m1_ack), 32'(m_busy && m_owner));
            check("m0_stall", 32'(m0_stall), 32'(m0_req && !(m_busy && !m_owner)));
            if (m_busy) begin
                check("dm_we_resp", 32'(dm_we), 0);
                m_busy = 0;
            end else if (m0_req || m1_req) begin
                bit win;
                bit w_we;
                logic [31:0] w_addr, w_data;
                logic [2:0] w_ty;
                int word;
                win    = (m0_req && m1_req) ? (m_run == LIMIT) : m1_req;
                w_we   = win ? m1_we : m0_we;
                w_addr = win ? m1_addr : m0_addr;
                w_data = win ? m1_wdata : m0_wdata;
                w_ty   = win ? m1_dmtype : m0_dmtype;
                word   = int'((w_addr / 4) % 128);
                check("dm_we_grant", 32'(dm_we), 32'(w_we));
                check("dm_addr_grant", 32'(dm_addr), 32'(word));
                check("dm_din_grant", dm_din, w_data);
                check("dm_type_grant", 32'(dm_type), 32'(w_ty));
                if (!win && m1_req) m_run = (m_run < LIMIT) ? m_run + 1 : LIMIT;
                else                m_run = 0;
                if (w_we) ref_mem[word] = w_data;
                else      m_last[win] = ref_mem[word];
                exp_q.push_back({win, m_last[win]});
                m_owner = win;
                m_busy  = 1;
            end else begin
                check("dm_idle", {dm_we, dm_type, dm_addr, 21'd0} | (dm_din != 0), 0);
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset && (m0_ack || m1_ack)) begin
            if (m0_ack && m1_ack) begin
                check("dual_ack", 32'(m0_ack & m1_ack), 0);
            end else if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(m1_ack), 32'hFFFF_FFFF);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("ack_port", 32'(m1_ack), 32'(e[32]));
                check("ack_rdata", m1_ack ? m1_rdata : m0_rdata, e[31:0]);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input int p, input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [2:0] ty);
        if (p == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = data; m0_dmtype = ty;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = data; m1_dmtype = ty;
        end
    endtask

    task automatic wait_ack(input int p);
        int n = 0;
        bit got = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            got = (p == 0) ? m0_ack : m1_ack;
        end
        if (!got) check("ack_timeout", 32'(p), 32'hFFFF_FFFF);
    endtask

    task automatic access(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] ty);
        @(posedge clk); #1;
        drive(p, 1'b1, we, addr, data, ty);
        wait_ack(p);
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic port_loop(input int p, input int n_ops);
        @(posedge clk); #1;
        for (int k = 0; k < n_ops; k++) begin
            logic [7:0] w;
            int g;
            w = 8'($urandom_range(0, 255));
            drive(p, 1'b1, 1'($urandom_range(0, 1)), {22'd0, w, 2'b00}, $urandom,
                  3'($urandom_range(0, 4)));
            wait_ack(p);
            @(posedge clk); #1;
            g = $urandom_range(0, 3);
            if (g > 0) begin
                drive(p, 1'b0, 1'b0, '0, '0, '0);
                repeat (g) @(posedge clk);
                #1;
            end
        end
        drive(p, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int exp_ord[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int got_ord[$];
        int a0, a1;

        for (int i = 0; i < 128; i++) begin dm_mem[i] = '0; ref_mem[i] = '0; end
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_m0_rdata", m0_rdata, 0);
        check("reset_m1_rdata", m1_rdata, 0);
        check("reset_acks", 32'({m0_ack, m1_ack}), 0);

        // CPU write then read back
        access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, DM_WORD);
        check("mem_word4", dm_mem[4], 32'hDEAD_BEEF);
        access(0, 1'b0, 32'h10, '0, DM_WORD);
        check("m0_readback", m0_rdata, 32'hDEAD_BEEF);

        // both requesting continuously: port 1 gets every fifth grant
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h10, '0, DM_WORD);
        drive(1, 1'b1, 1'b0, 32'h10, '0, DM_WORD);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m0_ack) got_ord.push_back(0);
            if (m1_ack) got_ord.push_back(1);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        check("starve_ack_count", got_ord.size(), 10);
        for (int i = 0; i < 10 && i < got_ord.size(); i++)
            check($sformatf("starve_order_%0d", i), got_ord[i], exp_ord[i]);

        // same-cycle request rise, CPU drops after its ack
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h10, '0, DM_WORD);
        drive(1, 1'b1, 1'b0, 32'h10, '0, DM_WORD);
        a0 = -1; a1 = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (m0_ack) a0 = c;
            if (m1_ack) a1 = c;
            @(posedge clk); #1;
            if (c == 1) drive(0, 1'b0, 1'b0, '0, '0, '0);
            if (c == 3) drive(1, 1'b0, 1'b0, '0, '0, '0);
        end
        check("same_cycle_m0_ack_at", a0, 1);
        check("same_cycle_m1_ack_at", a1, 3);

        // reset lands in the grant cycle of a port-1 write
        access(0, 1'b1, 32'h20, 32'h1234_5678, DM_WORD);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, DM_WORD);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        check("word8_unchanged", dm_mem[8], 32'h1234_5678);
        check("post_reset_m0_rdata", m0_rdata, 0);
        check("post_reset_m1_rdata", m1_rdata, 0);
        check("post_reset_acks", 32'({m0_ack, m1_ack}), 0);

        // reset lands in RESP of a CPU read; CPU keeps req high to reissue
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h20, '0, DM_WORD);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("resp_reset_m0_rdata", m0_rdata, 0);
        wait_ack(0);
        check("reissued_read", m0_rdata, 32'h1234_5678);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);

        // top word and its alias
        access(0, 1'b1, 32'h1FC, 32'hA5A5_5A5A, DM_WORD);
        access(1, 1'b0, 32'h3FC, '0, DM_WORD);
        check("alias_read", m1_rdata, 32'hA5A5_5A5A);
        access(1, 1'b0, 32'h1FC, '0, DM_BYTE_U);

        // random concurrent traffic
        fork
            port_loop(0, 40);
            port_loop(1, 40);
        join
        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
